// File: rtl/alu_serial_sequencer.sv
// alu_serial_sequencer
//
// Bit-serial ALU. An accepted start latches two WIDTH-bit operands and a
// 4-bit control code. The operation is then evaluated one bit per clock,
// LSB first, through a single 1-bit full-adder slice. The carry and the
// partial result are held in registers between cycles. The control
// encoding matches the bit-sliced ALU:
//   0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR.
// Any other code runs at full latency and produces a zero result with
// cleared flags.
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_start     request; sampled only in IDLE or DONE
//   i_ctrl      ALU control code
//   i_A, i_B    operands, sampled with an accepted start
//   o_busy      high while the bit loop is running
//   o_done      one-cycle pulse when the result becomes valid
//   o_result    result, held until the next completion
//   o_zero      o_result == 0
//   o_carryOut  carry out of the MSB (arithmetic ops only)
//   o_overflow  signed overflow (arithmetic ops only)
module alu_serial_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_ctrl,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_carryOut,
  output logic             o_overflow
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             carry_q,  carry_d;
  logic [3:0]       ctrl_q,   ctrl_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,   zero_d;
  logic             cout_q,   cout_d;
  logic             ovf_q,    ovf_d;

  // Per-bit datapath signals
  logic             is_arith;
  logic             inv_a;
  logic             inv_b;
  logic             a_bit;
  logic             b_bit;
  logic             sum_bit;
  logic             carry_next;
  logic             bit_out;
  logic             last_bit;
  logic             accept;
  logic             ovf_bit;
  logic [WIDTH-1:0] shifted_res;
  logic [WIDTH-1:0] final_res;

  always_comb begin
    is_arith = (ctrl_q == OP_ADD) || (ctrl_q == OP_SUB) || (ctrl_q == OP_SLT);
    inv_a    = (ctrl_q == OP_NOR);
    inv_b    = (ctrl_q == OP_SUB) || (ctrl_q == OP_SLT) || (ctrl_q == OP_NOR);

    a_bit      = a_sh_q[0] ^ inv_a;
    b_bit      = b_sh_q[0] ^ inv_b;
    sum_bit    = a_bit ^ b_bit ^ carry_q;
    carry_next = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);

    // NOR reuses the AND path on inverted inputs: ~A & ~B == ~(A | B).
    bit_out = 1'b0;
    case (ctrl_q)
      OP_AND:         bit_out = a_bit & b_bit;
      OP_NOR:         bit_out = a_bit & b_bit;
      OP_OR:          bit_out = a_bit | b_bit;
      OP_ADD, OP_SUB: bit_out = sum_bit;
      default:        bit_out = 1'b0;
    endcase

    last_bit    = (cnt_q == CNT_W'(WIDTH - 1));
    accept      = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    shifted_res = {bit_out, res_sh_q[WIDTH-1:1]};

    // At the MSB, carry_q is the carry-in and carry_next the carry-out.
    ovf_bit   = carry_q ^ carry_next;
    final_res = shifted_res;
    if (ctrl_q == OP_SLT) begin
      final_res    = '0;
      final_res[0] = sum_bit ^ ovf_bit;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    ctrl_d   = ctrl_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        res_sh_d = shifted_res;
        carry_d  = carry_next;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          result_d = final_res;
          zero_d   = (final_res == '0);
          cout_d   = is_arith & carry_next;
          ovf_d    = is_arith & ovf_bit;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      state_d  = ST_RUN;
      ctrl_d   = i_ctrl;
      a_sh_d   = i_A;
      b_sh_d   = i_B;
      cnt_d    = '0;
      res_sh_d = '0;
      // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
      carry_d  = (i_ctrl == OP_SUB) || (i_ctrl == OP_SLT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      ctrl_q   <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      ctrl_q   <= ctrl_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_busy     = (state_q == ST_RUN);
  assign o_done     = (state_q == ST_DONE);
  assign o_result   = result_q;
  assign o_zero     = zero_q;
  assign o_carryOut = cout_q;
  assign o_overflow = ovf_q;

endmodule
